// File: rtl/multdiv_sequencer.sv
// Sequences mul/div from X: start pulse, pipeline stall, timeout, one-cycle writeback.
// Latency: START one cycle after accept, DONE one cycle after result (or TIMEOUT WAIT cycles); TIMEOUT must be 1..63.
module multdiv_sequencer #(
    parameter int unsigned TIMEOUT     = 40,
    parameter logic [4:0]  RSTATUS_REG = 5'd30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        x_valid,
    input  logic [4:0]  opcode_x,
    input  logic [4:0]  alu_op_x,
    input  logic [4:0]  rd_x,
    input  logic        flush,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    input  logic [31:0] data_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        busy,
    output logic        md_wb_valid,
    output logic [4:0]  md_wb_rd,
    output logic [31:0] md_wb_data
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [4:0] OPC_ALU = 5'b00000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);
    localparam logic [5:0] CNT_MAX  = 6'h3f;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [5:0]  cnt;
    logic        op_div;
    logic [4:0]  rd_lat;
    logic [31:0] res_lat;
    logic        exc_lat;
    logic        req;
    logic        accept;

    assign req    = x_valid && (opcode_x == OPC_ALU) &&
                    ((alu_op_x == ALU_MUL) || (alu_op_x == ALU_DIV));
    assign accept = (state == IDLE) && req && !flush;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   state_nxt = flush ? IDLE : WAIT;
            WAIT: begin
                if (flush)
                    state_nxt = IDLE;
                else if (data_resultRDY || (cnt == CNT_LAST))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            op_div  <= 1'b0;
            rd_lat  <= 5'd0;
            res_lat <= 32'd0;
            exc_lat <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div  <= (alu_op_x == ALU_DIV);
                        rd_lat  <= rd_x;
                        res_lat <= 32'd0;
                        exc_lat <= 1'b0;
                    end
                end
                START: cnt <= 6'd0;
                WAIT: begin
                    if (cnt != CNT_MAX)
                        cnt <= cnt + 6'd1;
                    // A result arriving on the last allowed cycle still wins over the timeout.
                    if (!flush) begin
                        if (data_resultRDY) begin
                            res_lat <= data_result;
                            exc_lat <= data_exception;
                        end else if (cnt == CNT_LAST) begin
                            exc_lat <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ctrl_mult   = (state == START) && !op_div;
    assign ctrl_div    = (state == START) && op_div;
    assign busy        = (state != IDLE);
    assign md_wb_valid = (state == DONE);
    // Stall drops in DONE so the instruction leaves X on that edge and cannot retrigger.
    assign stall       = accept || (state == START) || (state == WAIT);

    always_comb begin
        md_wb_rd   = 5'd0;
        md_wb_data = 32'd0;
        if (state == DONE) begin
            if (exc_lat) begin
                md_wb_rd   = RSTATUS_REG;
                md_wb_data = op_div ? 32'd5 : 32'd4;
            end else begin
                md_wb_rd   = rd_lat;
                md_wb_data = res_lat;
            end
        end
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: directed table, hand sequences and random ops against a transaction-level model.
module tb_multdiv_sequencer;
    localparam int TMO = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        x_valid;
    logic [4:0]  opcode_x;
    logic [4:0]  alu_op_x;
    logic [4:0]  rd_x;
    logic        flush;
    logic        data_resultRDY;
    logic        data_exception;
    logic [31:0] data_result;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        busy;
    logic        md_wb_valid;
    logic [4:0]  md_wb_rd;
    logic [31:0] md_wb_data;

    multdiv_sequencer #(.TIMEOUT(TMO), .RSTATUS_REG(5'd30)) dut (
        .clock(clock), .reset(reset), .x_valid(x_valid), .opcode_x(opcode_x),
        .alu_op_x(alu_op_x), .rd_x(rd_x), .flush(flush),
        .data_resultRDY(data_resultRDY), .data_exception(data_exception),
        .data_result(data_result), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .stall(stall), .busy(busy), .md_wb_valid(md_wb_valid),
        .md_wb_rd(md_wb_rd), .md_wb_data(md_wb_data)
    );

    always #5 clock = ~clock;

    // k: RDY arrives at the k-th WAIT cycle (0 = never); flush_c: cycle index of flush (-1 = none),
    // where cycle 0 is the request cycle.
    typedef struct {
        bit          is_div;
        logic [4:0]  rd;
        int          k;
        bit          exc;
        logic [31:0] res;
        int          flush_c;
        int          exp_pulse;
        int          exp_wb;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        int          exp_stall;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic vec_t model(vec_t v);
        vec_t r = v;
        bit   got_rdy = (v.k >= 1) && (v.k <= TMO);
        int   done_c  = got_rdy ? v.k + 2 : TMO + 2;
        if (v.flush_c == 0) begin
            r.exp_pulse = 0; r.exp_wb = 0; r.exp_rd = 0; r.exp_data = 0; r.exp_stall = 0;
        end else if (v.flush_c > 0 && v.flush_c < done_c) begin
            r.exp_pulse = 1; r.exp_wb = 0; r.exp_rd = 0; r.exp_data = 0; r.exp_stall = v.flush_c + 1;
        end else begin
            r.exp_pulse = 1;
            r.exp_wb    = 1;
            r.exp_stall = done_c;
            if (!got_rdy || v.exc) begin
                r.exp_rd   = 5'd30;
                r.exp_data = v.is_div ? 32'd5 : 32'd4;
            end else begin
                r.exp_rd   = v.rd;
                r.exp_data = v.res;
            end
        end
        return r;
    endfunction

    // Acts as the pipeline: the instruction stays in X while stall is high and leaves on a
    // low-stall edge or when flushed; the core result is driven regardless of the instruction.
    task automatic run_op(input vec_t o, input string tag);
        int c = 0;
        bit in_x = 1'b1;
        bit left;
        bit rdy;
        int pulse_ok = 0, pulse_bad = 0, pulse_c = -1, st = 0, bz = 0;
        int wbn = 0, wb_c = -1, wb_st = 0;
        logic [4:0]  wrd = 0;
        logic [31:0] wdat = 0;
        int last_rdy = (o.k > 0) ? o.k + 1 : 0;
        while ((in_x || c <= last_rdy) && c < 200) begin
            rdy            = (o.k > 0) && (c == o.k + 1);
            x_valid        = in_x;
            opcode_x       = in_x ? 5'b00000 : 5'($urandom);
            alu_op_x       = o.is_div ? 5'b00111 : 5'b00110;
            rd_x           = o.rd;
            flush          = in_x && (c == o.flush_c);
            data_resultRDY = rdy;
            data_exception = rdy ? o.exc : 1'($urandom);
            data_result    = rdy ? o.res : $urandom;
            @(negedge clock);
            if (stall) st++;
            if (busy) bz++;
            if ((o.is_div && ctrl_div) || (!o.is_div && ctrl_mult)) begin
                pulse_ok++; pulse_c = c;
            end
            if ((o.is_div && ctrl_mult) || (!o.is_div && ctrl_div)) pulse_bad++;
            if (md_wb_valid) begin
                wbn++; wb_c = c; wrd = md_wb_rd; wdat = md_wb_data;
                if (stall) wb_st++;
            end
            left = !stall || flush;
            @(posedge clock); #1;
            if (left) in_x = 1'b0;
            c++;
        end
        x_valid = 1'b0; flush = 1'b0; data_resultRDY = 1'b0;
        chk({tag, " within_budget"}, 32'(c < 200), 32'd1);
        chk({tag, " start_pulses"}, pulse_ok, o.exp_pulse);
        chk({tag, " wrong_kind_pulses"}, pulse_bad, 0);
        if (o.exp_pulse > 0) chk({tag, " pulse_cycle"}, pulse_c, 1);
        chk({tag, " stall_cycles"}, st, o.exp_stall);
        chk({tag, " busy_cycles"}, bz, o.exp_wb > 0 ? o.exp_stall : (o.exp_pulse > 0 ? o.exp_stall - 1 : 0));
        chk({tag, " wb_count"}, wbn, o.exp_wb);
        if (o.exp_wb > 0) begin
            chk({tag, " wb_rd"}, wrd, o.exp_rd);
            chk({tag, " wb_data"}, wdat, o.exp_data);
            chk({tag, " wb_cycle"}, wb_c, o.exp_stall);
            chk({tag, " stall_in_done"}, wb_st, 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctrl_mult"}, ctrl_mult, 0);
        chk({tag, " ctrl_div"}, ctrl_div, 0);
        chk({tag, " stall"}, stall, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " wb_valid"}, md_wb_valid, 0);
        chk({tag, " wb_rd"}, md_wb_rd, 0);
        chk({tag, " wb_data"}, md_wb_data, 0);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        //         div rd  k   exc res            flush pulse wb rd  data           stall
        tbl.push_back('{0, 5, 17, 0, 32'h0000_0C00, -1, 1, 1, 5,  32'h0000_0C00, 19});
        tbl.push_back('{1, 7,  3, 1, 32'h0000_1234, -1, 1, 1, 30, 32'd5,         5});
        tbl.push_back('{0, 9,  1, 1, 32'h0000_DEAD, -1, 1, 1, 30, 32'd4,         3});
        tbl.push_back('{1, 12, 0, 0, 32'h0,         -1, 1, 1, 30, 32'd5,         42});
        tbl.push_back('{0, 3,  5, 0, 32'h0000_0055,  4, 1, 0, 0,  32'd0,         5});
        tbl.push_back('{1, 31, 40, 0, 32'hCAFE_0001, -1, 1, 1, 31, 32'hCAFE_0001, 42});
        tbl.push_back('{0, 1, 41, 0, 32'h0000_0077, -1, 1, 1, 30, 32'd4,         42});
        tbl.push_back('{1, 13, 3, 0, 32'h0000_0099,  1, 1, 0, 0,  32'd0,         2});
        tbl.push_back('{0, 10, 2, 0, 32'h0000_ABCD,  4, 1, 1, 10, 32'h0000_ABCD, 4});
        tbl.push_back('{0, 2,  2, 0, 32'h0000_0011,  0, 0, 0, 0,  32'd0,         0});
        tbl.push_back('{0, 0,  5, 0, 32'hFFFF_FFFF, -1, 1, 1, 0,  32'hFFFF_FFFF, 7});

        reset = 1'b1; x_valid = 1'b0; opcode_x = 0; alu_op_x = 0; rd_x = 0;
        flush = 1'b0; data_resultRDY = 1'b0; data_exception = 1'b0; data_result = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk_all_zero("reset");
        @(posedge clock); #1;

        for (int i = 0; i < tbl.size(); i++)
            run_op(tbl[i], $sformatf("tbl%0d", i));

        // Back-to-back: the div enters X the cycle after the mul's DONE.
        run_op(model('{0, 6, 4, 0, 32'h0000_0600, -1, 0, 0, 0, 0, 0}), "b2b_mul");
        run_op(model('{1, 8, 2, 0, 32'h0000_0008, -1, 0, 0, 0, 0, 0}), "b2b_div");

        // Stray result while idle must be ignored.
        data_resultRDY = 1'b1; data_result = 32'h1111_2222;
        @(posedge clock); #1 data_resultRDY = 1'b0;
        @(negedge clock);
        chk_all_zero("stray_rdy");
        @(posedge clock); #1;

        // Reset in the middle of WAIT.
        x_valid = 1'b1; opcode_x = 0; alu_op_x = 5'b00110; rd_x = 5'd4;
        repeat (5) @(posedge clock);
        #1;
        @(negedge clock);
        chk("mid_reset pre_busy", busy, 1);
        reset = 1'b1; x_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk_all_zero("mid_reset");
        @(posedge clock); #1;
        run_op(model('{0, 4, 3, 0, 32'h0000_4444, -1, 0, 0, 0, 0, 0}), "after_reset");

        for (int i = 0; i < 30; i++) begin
            v.is_div  = 1'($urandom);
            v.rd      = 5'($urandom);
            v.k       = int'($urandom_range(0, 45));
            v.exc     = ($urandom_range(0, 3) == 0);
            v.res     = $urandom;
            v.flush_c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 44)) : -1;
            run_op(model(v), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clock); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Sequences the multi-cycle multiply/divide unit for the five-stage processor. It detects a `mul`/`div` instruction in the execute stage, issues the one-cycle start pulse to the multdiv core, and stalls the front of the pipeline until the core reports a result or a timeout expires. It then presents a one-cycle writeback request, including the exception status code, to the memory/writeback path. It sits beside the X-stage control decode and owns the pipeline stall for multdiv operations.

## Interface
- `TIMEOUT`, default 40: wait cycles allowed before the operation is declared failed; must be ≤ 63.
- `RSTATUS_REG`, default 30: destination register written on exception.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `x_valid` in 1: X stage holds a valid, unflushed instruction.
- `opcode_x` in 5: opcode of the X-stage instruction.
- `alu_op_x` in 5: ALU op field of the X-stage instruction.
- `rd_x` in 5: destination register of the X-stage instruction.
- `flush` in 1: branch/jump flush of X; aborts any operation in progress.
- `data_resultRDY` in 1: multdiv core result valid (one-cycle pulse).
- `data_exception` in 1: multdiv core overflow/divide-by-zero; qualified by `data_resultRDY`.
- `data_result` in 32: multdiv core result.
- `ctrl_mult` out 1: one-cycle multiply start pulse.
- `ctrl_div` out 1: one-cycle divide start pulse.
- `stall` out 1: holds PC, F/D and D/X latches.
- `busy` out 1: FSM not in IDLE.
- `md_wb_valid` out 1: one-cycle writeback request.
- `md_wb_rd` out 5: writeback register.
- `md_wb_data` out 32: writeback value.

## Operation
- Request: `req = x_valid & opcode_x==5'b00000 & (alu_op_x==5'b00110 | alu_op_x==5'b00111)`. `00110` is mul; `00111` is div.
- States:
  - IDLE:
    - On `req & !flush`: latch op kind and `rd_x`, then go to START.
    - Otherwise stay in IDLE.
  - START:
    - `ctrl_mult` (mul) or `ctrl_div` (div) is high for exactly this cycle.
    - Wait counter clears to 0.
    - Go to WAIT.
  - WAIT:
    - Counter increments each cycle.
    - If `data_resultRDY`: latch `data_result` and `data_exception`, then go to DONE.
    - Else if counter==TIMEOUT-1: latch exception=1, then go to DONE.
  - DONE:
    - `md_wb_valid`=1.
    - Go to IDLE.
- Writeback, normal: `md_wb_rd` = latched rd, `md_wb_data` = latched result.
- Writeback on exception or timeout: `md_wb_rd`=RSTATUS_REG and `md_wb_data`=32'd4 (mul) or 32'd5 (div).
- `stall` = (IDLE & req & !flush) | START | WAIT. It is low in DONE, so the instruction leaves X on the DONE edge and cannot re-trigger.
- `flush` in START or WAIT: next state IDLE, no writeback, and core results arriving later are ignored. `flush` has no effect in DONE; the writeback still occurs.
- `data_resultRDY` seen in IDLE, START or DONE is ignored.
- The counter saturates; it never wraps.

## Timing
- Reset (synchronous, next edge): state IDLE, counter 0, all latched fields 0. Every output is 0 after reset: `ctrl_mult`, `ctrl_div`, `stall`, `busy`, `md_wb_valid`, `md_wb_rd`, `md_wb_data`.
- `reset` mid-operation: IDLE on the next edge, no start pulse, no writeback.
- Cycle N: `req` in IDLE, `stall`=1 combinationally.
- Cycle N+1: START, start pulse high.
- `data_resultRDY` at cycle N+1+k (k≥1) → DONE at N+2+k, with `md_wb_valid` high that cycle → IDLE at N+3+k.
- Timeout with no RDY: DONE at cycle N+2+TIMEOUT.
- `busy` is high in START, WAIT and DONE.
- A new `req` is accepted in the first IDLE cycle after DONE; back-to-back operations cost no bubble beyond DONE.
- Outputs other than `stall` are registered-state decodes; the stall path is combinational from inputs.

## Test plan
- mul, rd=5, RDY at 17th WAIT cycle with result 32'h0000_0C00:
  - `ctrl_mult` pulse exactly one cycle.
  - `stall` high 19 cycles.
  - `md_wb_valid` one cycle with rd=5, data=32'h0000_0C00.
  - `ctrl_div` never high.
- div, RDY with `data_exception`=1: writeback rd=30, data=5. Same for mul with exception: rd=30, data=4.
- div with no RDY and TIMEOUT=40: DONE exactly 41 cycles after START, writeback rd=30, data=5, `stall` drops in DONE.
- `flush` in the 3rd WAIT cycle, then RDY two cycles later: FSM returns to IDLE, `md_wb_valid` never asserts, `stall` low the cycle after the flush.
- `reset` asserted in WAIT: every output is 0 on the next cycle. A following mul request starts cleanly with one `ctrl_mult` pulse.
- Back-to-back: mul then div; the div is seen in X the cycle after DONE. The div is accepted in that cycle, START follows, and there are exactly two writebacks in order (mul rd, then div rd).
